// File: rtl/pic_command_write_handler.sv
// Write-side command decoder of the 8259 PIC: runs the ICW1-ICW4 init sequence, then decodes
// OCW1-OCW3. Define PIC_CASCADE_EN to keep the ICW3 state and honour SNGL.
module pic_command_write_handler (
  input  logic       clk,
  input  logic       rst_neg,
  input  logic       cs_neg,
  input  logic       wr_neg,
  input  logic       rd_neg,
  input  logic       a0,
  input  logic [0:7] data_in,
  output logic [0:7] imr,
  output logic [0:1] read_type_flag,
  output logic       init_done,
  output logic [0:4] vector_base,
  output logic       ltim,
  output logic       single_mode,
  output logic [0:7] icw3,
  output logic       aeoi,
  output logic       master_slave,
  output logic       buffered,
  output logic       sfnm,
  output logic       special_mask,
  output logic       ocw2_valid,
  output logic [0:2] ocw2_cmd,
  output logic [0:2] ocw2_level,
  output logic       poll_cmd
);

  // Bus index of each data bit: data_in[0] carries D7.
  localparam int unsigned BitD6 = 1;
  localparam int unsigned BitD5 = 2;
  localparam int unsigned BitD4 = 3;
  localparam int unsigned BitD3 = 4;
  localparam int unsigned BitD2 = 5;
  localparam int unsigned BitD1 = 6;
  localparam int unsigned BitD0 = 7;

`ifdef PIC_CASCADE_EN
  typedef enum logic [2:0] {StIcw1Wait, StIcw2, StIcw3, StIcw4, StReady} state_e;
`else
  typedef enum logic [2:0] {StIcw1Wait, StIcw2, StIcw4, StReady} state_e;
`endif

  state_e     state_q;
  state_e     icw2_next;
  logic       wr_q;
  logic       skip_q;
  logic       a0_q;
  logic [0:7] data_q;
  logic       ic4_q;
  logic       wr_active;
  logic       commit;
  logic       is_icw1;

`ifdef PIC_CASCADE_EN
  logic       sngl_q;
  logic [0:7] icw3_q;

  assign single_mode = sngl_q;
  assign icw3        = icw3_q;
`else
  assign single_mode = 1'b1;
  assign icw3        = 8'h00;
`endif

  assign init_done = (state_q == StReady);

  always_comb begin
    wr_active = !cs_neg && !wr_neg && rd_neg;
    commit    = wr_q && !wr_active;
    is_icw1   = !a0_q && data_q[BitD4];
    icw2_next = ic4_q ? StIcw4 : StReady;
`ifdef PIC_CASCADE_EN
    if (!sngl_q) icw2_next = StIcw3;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_neg) begin
      state_q        <= StIcw1Wait;
      wr_q           <= 1'b0;
      // A write still active when reset releases is ignored until the bus goes idle.
      skip_q         <= 1'b1;
      a0_q           <= 1'b0;
      data_q         <= 8'h00;
      ic4_q          <= 1'b0;
      imr            <= 8'h00;
      read_type_flag <= 2'b01;
      vector_base    <= 5'b00000;
      ltim           <= 1'b0;
      aeoi           <= 1'b0;
      master_slave   <= 1'b0;
      buffered       <= 1'b0;
      sfnm           <= 1'b0;
      special_mask   <= 1'b0;
      ocw2_valid     <= 1'b0;
      ocw2_cmd       <= 3'b000;
      ocw2_level     <= 3'b000;
      poll_cmd       <= 1'b0;
`ifdef PIC_CASCADE_EN
      sngl_q         <= 1'b0;
      icw3_q         <= 8'h00;
`endif
    end else begin
      ocw2_valid <= 1'b0;
      poll_cmd   <= 1'b0;

      if (wr_active) begin
        wr_q <= !skip_q;
        if (!skip_q) begin
          a0_q   <= a0;
          data_q <= data_in;
        end
      end else begin
        wr_q   <= 1'b0;
        skip_q <= 1'b0;
      end

      if (commit) begin
        if (is_icw1) begin
          ltim           <= data_q[BitD3];
          ic4_q          <= data_q[BitD0];
          imr            <= 8'h00;
          special_mask   <= 1'b0;
          aeoi           <= 1'b0;
          master_slave   <= 1'b0;
          buffered       <= 1'b0;
          sfnm           <= 1'b0;
          read_type_flag <= 2'b01;
          state_q        <= StIcw2;
`ifdef PIC_CASCADE_EN
          sngl_q         <= data_q[BitD1];
`endif
        end else begin
          case (state_q)
            StIcw2: begin
              if (a0_q) begin
                vector_base <= data_q[0:4];
                state_q     <= icw2_next;
              end
            end
`ifdef PIC_CASCADE_EN
            StIcw3: begin
              if (a0_q) begin
                icw3_q  <= data_q;
                state_q <= ic4_q ? StIcw4 : StReady;
              end
            end
`endif
            StIcw4: begin
              if (a0_q) begin
                aeoi         <= data_q[BitD1];
                master_slave <= data_q[BitD2];
                buffered     <= data_q[BitD3];
                sfnm         <= data_q[BitD4];
                state_q      <= StReady;
              end
            end
            StReady: begin
              if (a0_q) begin
                imr <= data_q;
              end else if (!data_q[BitD3]) begin
                ocw2_cmd   <= data_q[0:2];
                ocw2_level <= data_q[5:7];
                ocw2_valid <= 1'b1;
              end else begin
                if (data_q[BitD1]) read_type_flag <= data_q[BitD0] ? 2'b11 : 2'b01;
                if (data_q[BitD6]) special_mask <= data_q[BitD5];
                if (data_q[BitD2]) poll_cmd <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
